// File: rtl/key_event_arbiter.sv
// -----------------------------------------------------------------------------
// key_event_arbiter
//
// Purpose:
//   Collects single-cycle key pulses from N debounced keys. Each pulse is held
//   as a pending event, one per key. Events are handed one at a time to a
//   consumer over a valid/ready handshake. Grants are round-robin, so no key
//   can starve the others.
//
//   A pulse on a key that is already pending is dropped. Each cycle in which at
//   least one drop happens increments a saturating counter.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   key_pulse  one-cycle key press pulses, bit i = key i
//   en         1: accept new pulses; 0: pulses are ignored (not pended, not
//              counted as drops)
//   ev_valid   an event is being offered to the consumer
//   ev_id      index of the key for the offered event
//   ev_ready   consumer accepts the event when ev_valid && ev_ready at an edge
//   busy       any event pending or on offer
//   drop_cnt   number of cycles in which at least one pulse was dropped
//              (saturating)
//   clr_drop   synchronous clear of drop_cnt; wins over an increment
// -----------------------------------------------------------------------------
module key_event_arbiter #(
  parameter int N     = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     key_pulse,
  input  logic             en,
  output logic             ev_valid,
  output logic [ID_W-1:0]  ev_id,
  input  logic             ev_ready,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr_drop
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t          state;
  logic [N-1:0]    pending;
  logic [ID_W-1:0] rr_ptr;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            grant_fire;
  logic [N-1:0]    grant_mask;
  logic [ID_W:0]   scan_idx;
  logic [N-1:0]    new_pulse;
  logic [N-1:0]    drop_vec;
  logic            drop_any;

  // Saturating increment for the drop counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Next key index after id, wrapping N-1 -> 0. This also covers N that is
  // not a power of two.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    if (id == ID_W'(N - 1)) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  // Round-robin search. Scan upward from rr_ptr and take the first pending
  // key. scan_idx has one extra bit so that rr_ptr + k can be folded back
  // into 0..N-1 with a single subtract.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (scan_idx >= (ID_W + 1)'(N)) begin
        scan_idx = scan_idx - (ID_W + 1)'(N);
      end
      if (!grant_found && pending[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  assign grant_fire = (state == IDLE) && grant_found;

  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < N; i++) begin
      grant_mask[i] = grant_fire && (grant_idx == ID_W'(i));
    end
  end

  assign new_pulse = en ? key_pulse : '0;

  // A key that is granted on this edge frees its slot. A pulse on the same
  // edge therefore re-pends it instead of being dropped.
  assign drop_vec = new_pulse & pending & ~grant_mask;
  assign drop_any = |drop_vec;

  assign busy = (|pending) || ev_valid;

  // Pending set and event offer FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_id    <= '0;
      rr_ptr   <= '0;
    end else begin
      // A set wins over a clear on the same bit.
      pending <= (pending & ~grant_mask) | new_pulse;
      case (state)
        IDLE: begin
          if (grant_found) begin
            ev_id    <= grant_idx;
            ev_valid <= 1'b1;
            state    <= OFFER;
          end
        end
        OFFER: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            rr_ptr   <= wrap_inc(ev_id);
            state    <= IDLE;
          end
        end
        default: begin
          ev_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Drop counter
  always_ff @(posedge clk) begin
    if (rst || clr_drop) begin
      drop_cnt <= '0;
    end else if (drop_any) begin
      drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule
